// File: rtl/softmax_loader.sv
// Softmax coefficient loader: pops one packed word from the coefficient FIFO,
// streams its coefficients as valid/ready beats and reports their sum.
module softmax_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_OF_NODES   = 168,
  parameter int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
  parameter int SOFTMAX_WIDTH  = NUM_OF_NODES*DATA_WIDTH+NUM_NODE_WIDTH,
  parameter int SUM_WIDTH      = DATA_WIDTH+NUM_NODE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SOFTMAX_WIDTH-1:0]  fifo_data_i,
  input  logic                      fifo_empty_i,
  output logic                      fifo_rd_valid_o,
  output logic [DATA_WIDTH-1:0]     coef_o,
  output logic [NUM_NODE_WIDTH-1:0] coef_idx_o,
  output logic                      coef_valid_o,
  output logic                      coef_last_o,
  input  logic                      coef_ready_i,
  output logic [SUM_WIDTH-1:0]      sum_o,
  output logic                      sum_valid_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    POP_WAIT,
    STREAM,
    DONE
  } state_t;

  localparam logic [NUM_NODE_WIDTH-1:0] MAX_N =
    NUM_NODE_WIDTH'(NUM_OF_NODES);

  typedef logic [NUM_OF_NODES-1:0][DATA_WIDTH-1:0] coef_vec_t;

  state_t                    state;
  coef_vec_t                 coefs;
  coef_vec_t                 word_coefs;
  logic [NUM_NODE_WIDTH-1:0] cnt;
  logic [NUM_NODE_WIDTH-1:0] n_raw;
  logic [NUM_NODE_WIDTH-1:0] n_clamp;
  logic [SUM_WIDTH-1:0]      acc;
  logic [SUM_WIDTH-1:0]      acc_next;
  logic                      fire;

  assign n_raw      = fifo_data_i[NUM_NODE_WIDTH-1:0];
  assign n_clamp    = (n_raw > MAX_N) ? MAX_N : n_raw;
  assign word_coefs = fifo_data_i[SOFTMAX_WIDTH-1:NUM_NODE_WIDTH];
  assign fire       = coef_valid_o & coef_ready_i;
  assign acc_next   = acc + SUM_WIDTH'(coef_o);

  // Coefficients are shifted down so the current beat always sits in slot 0
  assign coef_o = coefs[0];

  // Pop is combinational so the word lands one cycle later in POP_WAIT
  assign fifo_rd_valid_o = rst_n & (state == IDLE) & ~fifo_empty_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      coefs        <= '0;
      cnt          <= '0;
      acc          <= '0;
      coef_idx_o   <= '0;
      coef_valid_o <= 1'b0;
      coef_last_o  <= 1'b0;
      sum_o        <= '0;
      sum_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          sum_valid_o <= 1'b0;
          if (!fifo_empty_i) begin
            state  <= POP_WAIT;
            busy_o <= 1'b1;
          end
        end
        POP_WAIT: begin
          coefs      <= word_coefs;
          cnt        <= n_clamp;
          coef_idx_o <= '0;
          acc        <= '0;
          if (n_clamp == '0) begin
            state       <= DONE;
            sum_o       <= '0;
            sum_valid_o <= 1'b1;
          end else begin
            state        <= STREAM;
            coef_valid_o <= 1'b1;
            coef_last_o  <= (n_clamp == NUM_NODE_WIDTH'(1));
          end
        end
        STREAM: begin
          if (fire) begin
            acc   <= acc_next;
            coefs <= coefs >> DATA_WIDTH;
            if (coef_last_o) begin
              state        <= DONE;
              coef_valid_o <= 1'b0;
              coef_last_o  <= 1'b0;
              sum_o        <= acc_next;
              sum_valid_o  <= 1'b1;
            end else begin
              coef_idx_o  <= coef_idx_o + NUM_NODE_WIDTH'(1);
              coef_last_o <= (coef_idx_o + NUM_NODE_WIDTH'(2)) == cnt;
            end
          end
        end
        DONE: begin
          sum_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/softmax_loader.md
SOFTMAX_LOADER -- requirements
Module: softmax_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one attention coefficient (unsigned).
REQ-002 SHALL have parameter NUM_OF_NODES, default 168, maximum coefficients per packed word.
REQ-003 SHALL have parameter NUM_NODE_WIDTH, default $clog2(NUM_OF_NODES), width of the node-count field.
REQ-004 SHALL have parameter SOFTMAX_WIDTH, default NUM_OF_NODES*DATA_WIDTH+NUM_NODE_WIDTH, packed FIFO word width.
REQ-005 SHALL have parameter SUM_WIDTH, default DATA_WIDTH+NUM_NODE_WIDTH, accumulator width.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port fifo_data_i  input  SOFTMAX_WIDTH  data from softmax coefficient FIFO.
REQ-009 SHALL have port fifo_empty_i  input  1  FIFO empty flag.
REQ-010 SHALL have port fifo_rd_valid_o  output  1  FIFO pop strobe.
REQ-011 SHALL have port coef_o  output  DATA_WIDTH  current coefficient.
REQ-012 SHALL have port coef_idx_o  output  NUM_NODE_WIDTH  index of coef_o within the word.
REQ-013 SHALL have port coef_valid_o  output  1  coefficient beat valid.
REQ-014 SHALL have port coef_last_o  output  1  marks final beat of a word.
REQ-015 SHALL have port coef_ready_i  input  1  downstream accepts beat.
REQ-016 SHALL have port sum_o  output  SUM_WIDTH  sum of all coefficients of the word.
REQ-017 SHALL have port sum_valid_o  output  1  one-cycle strobe qualifying sum_o.
REQ-018 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-019 Word layout SHALL be: bits [NUM_NODE_WIDTH-1:0] = node count n; coefficient k at bits [NUM_NODE_WIDTH+k*DATA_WIDTH +: DATA_WIDTH].
REQ-020 FIFO read latency SHALL be one cycle: data popped in cycle t is sampled from fifo_data_i in cycle t+1.
REQ-021 FSM states SHALL be IDLE, POP_WAIT, STREAM, DONE.
REQ-022 IDLE: if fifo_empty_i=0, assert fifo_rd_valid_o for exactly one cycle and go to POP_WAIT; else stay.
REQ-023 POP_WAIT: capture full word into internal register, n into count register, clear index and accumulator; go to DONE if n=0, else STREAM.
REQ-024 n greater than NUM_OF_NODES SHALL be clamped to NUM_OF_NODES.
REQ-025 STREAM: coef_valid_o=1, coef_o=coefficient[idx], coef_idx_o=idx, coef_last_o=(idx==n-1).
REQ-026 Beat transfers only when coef_valid_o and coef_ready_i both 1; on transfer accumulator += coef_o (zero-extended), idx increments.
REQ-027 While coef_valid_o=1 and coef_ready_i=0, coef_o, coef_idx_o, coef_last_o SHALL hold stable.
REQ-028 Transfer of last beat SHALL move FSM to DONE.
REQ-029 DONE: sum_valid_o=1 for exactly one cycle with final accumulator on sum_o; next state IDLE.
REQ-030 fifo_rd_valid_o SHALL never assert outside IDLE nor when fifo_empty_i=1 (no pop of empty FIFO).
REQ-031 First coef_valid_o SHALL assert 2 cycles after IDLE sees fifo_empty_i=0; minimum word period n+3 cycles.
REQ-032 Accumulator SHALL not overflow: SUM_WIDTH covers NUM_OF_NODES*(2^DATA_WIDTH-1); sum_o holds value until next DONE.

Reset
REQ-033 rst_n=0 SHALL asynchronously force FSM to IDLE and all outputs to 0 (fifo_rd_valid_o, coef_o, coef_idx_o, coef_valid_o, coef_last_o, sum_o, sum_valid_o, busy_o); internal word, idx, count, accumulator cleared.
REQ-034 Reset mid-STREAM SHALL abandon the current word with no sum_valid_o pulse; after release, operation restarts from IDLE with the next FIFO entry.

Verification
REQ-035 One word n=3, coefs 10,20,30, ready tied 1 -> single pop; beats 10,20,30 on consecutive cycles, last on third; sum_o=60 pulse next cycle.
REQ-036 Same word, coef_ready_i toggling 1,0,0,1,... -> outputs stable during stalls; same beat order; sum_o=60.
REQ-037 Word with n=0 -> one pop, no coef_valid_o, sum_valid_o pulse with sum_o=0, return to IDLE.
REQ-038 n=NUM_OF_NODES, all coefs 255 -> 168 beats, last on idx 167, sum_o=42840, no overflow.
REQ-039 Two back-to-back words in FIFO -> second pop only after first DONE; fifo_rd_valid_o exactly once per word; never asserted with empty=1.
REQ-040 rst_n dropped during beat 2 of n=5 word -> all outputs 0 immediately, no sum pulse; after release next word streams from idx 0.
